// File: rtl/bounce_emulator_pkg.sv
// bounce_emulator_pkg: shared types and constants for the switch-bounce generator.
package bounce_emulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Gap width: 16-bit masked LFSR plus MIN_GAP fits in 17 bits without overflow.
    localparam int GAP_W = 17;

    // One Galois step: shift right, fold the taps back in when a one falls out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/bounce_emulator_lfsr16.sv
// lfsr16: 16-bit Galois LFSR that steps only when enabled; reloads SEED on reset.
module lfsr16
    import bounce_emulator_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    // Hold the state, advancing by one Galois step on each enabled cycle.
    always_ff @(posedge i_clk) begin
        // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch.
        if (!i_reset_n) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/bounce_emulator.sv
// bounce_emulator: turns each change of clean_in into a burst of toggles followed
// by a settle period, for exercising a debouncer.
// Optional feature macro BOUNCE_EMULATOR_RANDOM_EN: when defined, each gap adds a
// masked LFSR value to MIN_GAP; when undefined, every gap is MIN_GAP + GAP_MASK.
module bounce_emulator
    import bounce_emulator_pkg::*;
#(
    parameter int          BOUNCE_COUNT  = 5,
    parameter int          MIN_GAP       = 4,
    parameter int          GAP_MASK      = 7,
    parameter int          SETTLE_CYCLES = 20,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clean_in,
    output logic noisy_out,
    output logic busy,
    output logic done
);

    localparam int TOG_W = $clog2(BOUNCE_COUNT + 1);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [TOG_W-1:0] TOG_MAX    = TOG_W'(BOUNCE_COUNT);
    localparam logic [SET_W-1:0] SET_RELOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [15:0]      MASK16     = 16'(GAP_MASK);

    state_t             r_state;
    logic               r_target;
    logic               r_noisy;
    logic               r_busy;
    logic               r_done;
    logic [TOG_W-1:0]   r_tog_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [SET_W-1:0]   r_set_cnt;

    logic               w_change;
    logic [GAP_W-1:0]   w_gap;

    assign w_change = (clean_in != r_target);

`ifdef BOUNCE_EMULATOR_RANDOM_EN
    logic        w_gap_load;
    logic [15:0] w_lfsr;

    // A gap is consumed on a new transition or on every mid-burst toggle.
    assign w_gap_load = w_change ||
                        ((r_state == ST_BOUNCE) && (r_gap_cnt == '0) && (r_tog_cnt < TOG_MAX));

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_en      (w_gap_load),
        .o_state   (w_lfsr)
    );

    assign w_gap = GAP_W'(MIN_GAP) + {1'b0, (w_lfsr & MASK16)};
`else
    assign w_gap = GAP_W'(MIN_GAP) + {1'b0, MASK16};
`endif

    // Burst/settle FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_target  <= 1'b0;
            r_noisy   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tog_cnt <= '0;
            r_gap_cnt <= '0;
            r_set_cnt <= '0;
        end else begin
            // NOTE: non-blocking throughout; the default-low done is overridden later in the same block.
            r_done <= 1'b0;
            if (w_change) begin
                // A new level always restarts the burst, even mid-bounce or mid-settle.
                r_target  <= clean_in;
                r_noisy   <= ~r_noisy;
                r_tog_cnt <= TOG_W'(1);
                r_gap_cnt <= w_gap - GAP_W'(1);
                r_busy    <= 1'b1;
                r_state   <= ST_BOUNCE;
            end else begin
                case (r_state)
                    ST_BOUNCE: begin
                        if (r_gap_cnt != '0) begin
                            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                        end else if (r_tog_cnt < TOG_MAX) begin
                            r_noisy   <= ~r_noisy;
                            r_tog_cnt <= r_tog_cnt + TOG_W'(1);
                            r_gap_cnt <= w_gap - GAP_W'(1);
                        end else begin
                            r_noisy   <= r_target;
                            r_set_cnt <= SET_RELOAD;
                            r_state   <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        r_noisy <= r_target;
                        if (r_set_cnt != '0) begin
                            r_set_cnt <= r_set_cnt - SET_W'(1);
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_noisy <= r_target;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign noisy_out = r_noisy;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_bounce_emulator.sv
// tb_bounce_emulator: directed checks of burst timing, restart, reset abort and
// debouncer interaction for bounce_emulator at default parameters.
module tb_bounce_emulator;

    localparam int          N_BOUNCE = 5;
    localparam int          MG       = 4;
    localparam int          GM       = 7;
    localparam int          SET      = 20;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam int          DEB_FINAL = 16;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic clean_in = 1'b0;
    logic noisy_out;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    bounce_emulator #(
        .BOUNCE_COUNT  (N_BOUNCE),
        .MIN_GAP       (MG),
        .GAP_MASK      (GM),
        .SETTLE_CYCLES (SET),
        .SEED          (SEED)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clean_in  (clean_in),
        .noisy_out (noisy_out),
        .busy      (busy),
        .done      (done)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr = SEED;
    logic        m_noisy = 1'b0;

    // Simple counter debouncer standing in for the design under exercise.
    logic deb = 1'b0;
    logic deb_last = 1'b0;
    int   deb_cnt = 0;
    int   deb_changes = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            deb      <= 1'b0;
            deb_last <= 1'b0;
            deb_cnt  <= 0;
        end else if (noisy_out != deb_last) begin
            deb_last <= noisy_out;
            deb_cnt  <= 0;
        end else if (deb_cnt < DEB_FINAL) begin
            deb_cnt <= deb_cnt + 1;
        end else if (deb != deb_last) begin
            deb         <= deb_last;
            deb_changes <= deb_changes + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference gap source: fixed without the macro, Galois LFSR model with it.
    task automatic take_gap(output int g);
`ifdef BOUNCE_EMULATOR_RANDOM_EN
        g = MG + int'(m_lfsr & 16'(GM));
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        check("gap_range", 32'((g >= MG) && (g <= MG + GM)), 32'd1);
`else
        g = MG + GM;
`endif
    endtask

    // Apply a level change just before the next edge and check the first toggle.
    task automatic trigger(input logic lvl, output int g);
        clean_in = lvl;
        step(1);
        take_gap(g);
        m_noisy = ~m_noisy;
        check("first_toggle", 32'(noisy_out), 32'(m_noisy));
        check("busy_rise", 32'(busy), 32'd1);
    endtask

    // Check toggles 2..N, the final level, the settle period and the done pulse.
    task automatic burst_tail(input logic tgt, input int g0);
        int g;
        g = g0;
        for (int i = 2; i <= N_BOUNCE; i++) begin
            step(g - 1);
            check("hold_before_toggle", 32'(noisy_out), 32'(m_noisy));
            check("no_done_bounce", 32'(done), 32'd0);
            step(1);
            m_noisy = ~m_noisy;
            check("toggle", 32'(noisy_out), 32'(m_noisy));
            take_gap(g);
        end
        step(g - 1);
        check("hold_before_final", 32'(noisy_out), 32'(m_noisy));
        step(1);
        m_noisy = tgt;
        check("final_level", 32'(noisy_out), 32'(tgt));
        check("busy_in_settle", 32'(busy), 32'd1);
        check("no_done_final", 32'(done), 32'd0);
        step(SET - 1);
        check("settle_level", 32'(noisy_out), 32'(tgt));
        check("no_done_early", 32'(done), 32'd0);
        check("busy_late_settle", 32'(busy), 32'd1);
        step(1);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_fall", 32'(busy), 32'd0);
        step(1);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_level", 32'(noisy_out), 32'(tgt));
    endtask

    initial begin
        int g;
        int cnt;
        int tog;
        int deb_before;

        // Reset held three cycles with clean_in low.
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_noisy", 32'(noisy_out), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        step(2);
        check("idle_noisy", 32'(noisy_out), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Full 0->1 burst; debouncer must change exactly once.
        deb_before = deb_changes;
        trigger(1'b1, g);
        burst_tail(1'b1, g);
        check("deb_once_rise", 32'(deb_changes - deb_before), 32'd1);
        check("deb_level_rise", 32'(deb), 32'd1);

        // Change back mid-burst at k+20: burst restarts, single done at the end.
        deb_before = deb_changes;
        trigger(1'b0, g);
        cnt = g - 1;
        tog = 1;
        for (int t = 1; t < 20; t++) begin
            step(1);
            if (cnt == 0 && tog < N_BOUNCE) begin
                m_noisy = ~m_noisy;
                tog++;
                take_gap(g);
                cnt = g - 1;
            end else begin
                cnt--;
            end
            check("pre_restart_noisy", 32'(noisy_out), 32'(m_noisy));
            check("pre_restart_done", 32'(done), 32'd0);
        end
        trigger(1'b1, g);
        burst_tail(1'b1, g);
        check("deb_restart_net", 32'(deb_changes - deb_before), 32'd0);

        // Full 1->0 burst; debouncer changes once.
        deb_before = deb_changes;
        trigger(1'b0, g);
        burst_tail(1'b0, g);
        check("deb_once_fall", 32'(deb_changes - deb_before), 32'd1);
        check("deb_level_fall", 32'(deb), 32'd0);

        // Reset asserted at k+30 aborts the burst; no done afterwards.
        trigger(1'b1, g);
        step(29);
        reset_n  = 1'b0;
        clean_in = 1'b0;
        step(1);
        check("abort_noisy", 32'(noisy_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        m_lfsr  = SEED;
        m_noisy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            check("post_abort_done", 32'(done), 32'd0);
            check("post_abort_noisy", 32'(noisy_out), 32'd0);
        end

        // Burst after reset uses the reseeded gap sequence.
        trigger(1'b1, g);
        burst_tail(1'b1, g);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
